game_round_ctrl: RTL
====================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter init_lives, default 3: lives loaded at reset and at each new game, range 1..3.
REQ-002 Parameter hold_frames, default 60: frame_strobe pulses counted in HIT and OVER, range 1..255.
REQ-003 Parameter idle_frames, default 300: frame_strobe pulses before auto-launch, used only with the macro, range 1..1023.
REQ-004 Parameter w_score, default 8: score width.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 launch_key  in  1  start request, level, synchronous to clk.
REQ-008 frame_strobe  in  1  one-cycle pulse per video frame.
REQ-009 collision  in  1  one-cycle pulse when the player sprite hits the target.
REQ-010 target_gone  in  1  one-cycle pulse when the target leaves the screen (miss).
REQ-011 start_sprites  out  1  one-cycle pulse that relaunches the sprites in game_top.
REQ-012 game_active  out  1  high in PLAY and HIT.
REQ-013 game_over  out  1  high in OVER.
REQ-014 score  out  w_score  hit count.
REQ-015 lives  out  2  remaining lives.
REQ-016 state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.

Function
REQ-017 All outputs are registered; no combinational input-to-output path.
REQ-018 Launch edge is defined as launch_key high while its one-cycle-delayed registered copy is low.
REQ-019 IDLE, on a launch edge: go to PLAY next cycle, clear score, load lives=init_lives, pulse start_sprites in that same next cycle.
REQ-020 PLAY, on collision: increment score, saturating at 2^w_score-1, then go to HIT.
REQ-021 PLAY, on target_gone with lives>1: decrement lives, stay in PLAY, pulse start_sprites next cycle.
REQ-022 PLAY, on target_gone with lives==1: set lives=0 and go to OVER.
REQ-023 PLAY, collision and target_gone in the same cycle: collision wins; target_gone is discarded.
REQ-024 HIT: count frame_strobe pulses; on pulse number hold_frames, go to PLAY and pulse start_sprites next cycle; collision and target_gone are ignored.
REQ-025 OVER: count frame_strobe pulses; on pulse number hold_frames, go to IDLE; launch edges during OVER are ignored; score and lives are held.
REQ-026 Frame counter clears on every state entry.
REQ-027 start_sprites is never high for two consecutive cycles.
REQ-028 frame_strobe coincident with a state-changing event is not counted in the new state.

Reset
REQ-029 While rst is high, on each clk edge: state=IDLE, score=0, lives=init_lives, start_sprites=0, game_active=0, game_over=0, frame counter=0, launch_key delay register=0.
REQ-030 rst asserted mid-game aborts the round with no start_sprites pulse; a launch_key held high through reset does not launch until it is released and pressed again.

Configuration
REQ-031 Macro GAME_ROUND_CTRL_AUTOLAUNCH_EN defined: in IDLE, after idle_frames frame_strobe pulses with no launch edge, the block behaves exactly as on a launch edge (REQ-019).
REQ-032 Macro GAME_ROUND_CTRL_AUTOLAUNCH_EN undefined: IDLE exits only on a launch edge; idle_frames has no effect.

Verification (bench parameters: hold_frames=2, init_lives=3, idle_frames=4, w_score=8)
REQ-033 Reset, then launch_key 0->1 -> exactly one start_sprites pulse, state=1, lives=3, score=0.
REQ-034 In PLAY, collision, then 2 frame_strobe pulses -> score=1, state=2 until the 2nd pulse, then state=1 with one start_sprites pulse.
REQ-035 In PLAY, 3 target_gone pulses -> lives 2, 1, then 0; start_sprites pulses twice; state=3, game_over=1; after 2 frame_strobe pulses, state=0.
REQ-036 collision and target_gone in the same cycle with lives=1 -> score+1, lives=1, state=2.
REQ-037 Score preloaded to 255 through 255 hits -> one more collision leaves score at 255.
REQ-038 With the macro defined, 4 frame_strobe pulses in IDLE -> start_sprites pulse, state=1; with the macro undefined, state stays 0.

Source files
------------

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round/lives/score sequencer for the sprite game
// Optional idle auto-launch enabled by macro GAME_ROUND_CTRL_AUTOLAUNCH_EN.
module game_round_ctrl #(
  parameter int init_lives  = 3,
  parameter int hold_frames = 60,
  parameter int idle_frames = 300,
  parameter int w_score     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               launch_key,
  input  logic               frame_strobe,
  input  logic               collision,
  input  logic               target_gone,
  output logic               start_sprites,
  output logic               game_active,
  output logic               game_over,
  output logic [w_score-1:0] score,
  output logic [1:0]         lives,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int CNT_MAX = (hold_frames > idle_frames) ? hold_frames : idle_frames;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(hold_frames - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(init_lives);
  localparam logic [w_score-1:0] SCORE_MAX = {w_score{1'b1}};
`ifdef GAME_ROUND_CTRL_AUTOLAUNCH_EN
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(idle_frames - 1);
`endif

  state_t             state_q, state_d;
  logic [w_score-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q, start_d;
  logic               active_q, over_q;
  logic               key_q;
  logic               key_block_q;
  logic               launch_edge;

  // A key held through reset stays blocked until it has been seen released.
  assign launch_edge = launch_key & ~key_q & ~key_block_q;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch_edge) begin
          state_d = PLAY;
          score_d = '0;
          lives_d = LIVES_INIT;
          start_d = 1'b1;
          cnt_d   = '0;
        end
`ifdef GAME_ROUND_CTRL_AUTOLAUNCH_EN
        else if (frame_strobe) begin
          if (cnt_q == IDLE_LAST) begin
            state_d = PLAY;
            score_d = '0;
            lives_d = LIVES_INIT;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      PLAY: begin
        if (collision) begin
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          state_d = HIT;
          cnt_d   = '0;
        end else if (target_gone) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            start_d = 1'b1;
          end else begin
            lives_d = 2'd0;
            state_d = OVER;
            cnt_d   = '0;
          end
        end
      end
      HIT: begin
        if (frame_strobe) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = PLAY;
            start_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (frame_strobe) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    // Back-to-back relaunch requests collapse into the pulse already issued.
    if (start_q) start_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      over_q      <= 1'b0;
      key_q       <= 1'b0;
      key_block_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      active_q    <= (state_d == PLAY) || (state_d == HIT);
      over_q      <= (state_d == OVER);
      key_q       <= launch_key;
      if (!launch_key) key_block_q <= 1'b0;
    end
  end

  assign start_sprites = start_q;
  assign game_active   = active_q;
  assign game_over     = over_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign state         = state_q;

endmodule
